// File: rtl/NanoCore_pkg.sv
// NanoCore shared fetch types.
// Holds the predictor update payload, the per-slot prediction info handed to
// decode, the predictor table entry layout, the fetch FSM state enum and the
// reset value of a freshly written branch-history counter.
package NanoCore_pkg;

  localparam int         PRED_ID_W = 4;
  localparam logic [1:0] BHT_INIT  = 2'b01;

  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    STALL
  } ifu_state_e;

  typedef struct packed {
    logic                 insert;
    logic                 is_jal;
    logic [31:0]          pc;
    logic [31:0]          tgt;
    logic [PRED_ID_W-1:0] entry_id;
    logic                 upd_tgt;
    logic                 upd_bht;
    logic                 inc_bht;
  } pred_upd_t;

  typedef struct packed {
    logic                 hit;
    logic                 taken;
    logic [31:0]          tgt;
    logic [31:0]          pc;
    logic [PRED_ID_W-1:0] entry_id;
  } pred_info_t;

  // tag and tgt only ever hold the low TAG_W bits; the upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic        is_jal;
    logic [31:0] tag;
    logic [31:0] tgt;
    logic [1:0]  bht;
  } pred_entry_t;

  // Mask selecting the low w bits of a 32-bit word.
  function automatic logic [31:0] low_mask(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/nc_pred_table.sv
// Merged BTB / static jal predictor table.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   upd_v_i       update strobe
//   upd_i         update payload (insert or counter/target update)
//   lookup_pc_i   one PC per fetch slot
//   lookup_o      per-slot hit/taken/target/pc/entry_id, combinational
// Entries are replaced round-robin on insert of an unknown PC.
module nc_pred_table
  import NanoCore_pkg::*;
#(
  parameter int FETCH_W     = 2,
  parameter int BTB_ENTRIES = 4,
  parameter int TAG_W       = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          upd_v_i,
  input  pred_upd_t                     upd_i,
  input  logic       [FETCH_W-1:0][31:0] lookup_pc_i,
  output pred_info_t [FETCH_W-1:0]       lookup_o
);

  localparam int          RRW      = $clog2(BTB_ENTRIES);
  localparam logic [31:0] TAG_MASK = low_mask(TAG_W);

  pred_entry_t [BTB_ENTRIES-1:0] entries;
  logic [RRW-1:0]                rr_ptr;
  logic                          upd_hit;
  logic [RRW-1:0]                upd_hit_idx;
  logic [RRW-1:0]                upd_id;
  logic [1:0]                    bht_cur;
  logic [1:0]                    bht_next;

  // Parallel lookup; the table never holds duplicate tags, so at most one
  // entry matches per slot. The predicted target keeps the slot's upper bits.
  always_comb begin
    for (int s = 0; s < FETCH_W; s++) begin
      lookup_o[s]    = '0;
      lookup_o[s].pc = lookup_pc_i[s];
      for (int e = 0; e < BTB_ENTRIES; e++) begin
        if (entries[e].valid && (entries[e].tag == (lookup_pc_i[s] & TAG_MASK))) begin
          lookup_o[s].hit      = 1'b1;
          lookup_o[s].taken    = entries[e].is_jal | entries[e].bht[1];
          lookup_o[s].tgt      = (lookup_pc_i[s] & ~TAG_MASK) | entries[e].tgt;
          lookup_o[s].entry_id = PRED_ID_W'(e);
        end
      end
    end
  end

  // Locate an existing entry for an insert so re-inserts overwrite in place.
  always_comb begin
    upd_hit     = 1'b0;
    upd_hit_idx = '0;
    for (int e = 0; e < BTB_ENTRIES; e++) begin
      if (entries[e].valid && (entries[e].tag == (upd_i.pc & TAG_MASK))) begin
        upd_hit     = 1'b1;
        upd_hit_idx = RRW'(e);
      end
    end
  end

  // Saturating two-bit counter step for the addressed entry.
  always_comb begin
    upd_id  = upd_i.entry_id[RRW-1:0];
    bht_cur = entries[upd_id].bht;
    if (upd_i.inc_bht) bht_next = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'b01;
    else               bht_next = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'b01;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entries <= '0;
      rr_ptr  <= '0;
    end else if (upd_v_i) begin
      if (upd_i.insert) begin
        if (upd_hit) begin
          entries[upd_hit_idx].tgt    <= upd_i.tgt & TAG_MASK;
          entries[upd_hit_idx].is_jal <= upd_i.is_jal;
          entries[upd_hit_idx].bht    <= BHT_INIT;
        end else begin
          entries[rr_ptr] <= '{valid:  1'b1,
                                is_jal: upd_i.is_jal,
                                tag:    upd_i.pc & TAG_MASK,
                                tgt:    upd_i.tgt & TAG_MASK,
                                bht:    BHT_INIT};
          rr_ptr <= (rr_ptr == RRW'(BTB_ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
        end
      end else if (int'(upd_i.entry_id) < BTB_ENTRIES) begin
        if (upd_i.upd_tgt) entries[upd_id].tgt <= upd_i.tgt & TAG_MASK;
        if (upd_i.upd_bht) entries[upd_id].bht <= bht_next;
      end
    end
  end

endmodule

// File: rtl/nc_ifu_multi.sv
// NanoCore multi-instruction fetch unit.
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   flush_i         redirect strobe, branch_pc_i the redirect target
//   instr_req_o     fetch request, instr_gnt_i accepts it
//   instr_mask_o    slots requested within the aligned block
//   instr_addr_o    word-aligned fetch PC
//   iq_rd_ptr_i     consumer read pointer, iq_wr_ptr_o prefetch pointer
//   upd_v_i/upd_i   predictor update
//   pred_v_o/pred_o per-slot prediction info, one cycle after grant
module nc_ifu_multi
  import NanoCore_pkg::*;
#(
  parameter int          FETCH_W        = 2,
  parameter int          IQ_DEPTH       = 8,
  parameter int          BTB_ENTRIES    = 4,
  parameter int          TAG_W          = 16,
  parameter logic [31:0] PROGADDR_RESET = 32'h0,
  localparam int         PW             = $clog2(IQ_DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_i,
  input  logic [31:0]              branch_pc_i,
  input  logic                     instr_gnt_i,
  output logic                     instr_req_o,
  output logic [FETCH_W-1:0]       instr_mask_o,
  output logic [31:0]              instr_addr_o,
  input  logic [PW:0]              iq_rd_ptr_i,
  output logic [PW:0]              iq_wr_ptr_o,
  input  logic                     upd_v_i,
  input  pred_upd_t                upd_i,
  output logic [FETCH_W-1:0]       pred_v_o,
  output pred_info_t [FETCH_W-1:0] pred_o
);

  localparam logic [31:0] BLOCK_MASK = 32'(4 * FETCH_W - 1);
  localparam logic [31:0] TAG_MASK   = low_mask(TAG_W);

  ifu_state_e                state_q, state_d;
  logic [31:0]               pc_q, pc_d;
  logic [PW:0]               wr_ptr_q;
  logic [FETCH_W-1:0]        pred_v_q;
  pred_info_t [FETCH_W-1:0]  pred_q;
  pred_info_t [FETCH_W-1:0]  look;
  logic [FETCH_W-1:0][31:0]  slot_pc;
  logic [31:0]               start_slot;
  logic [FETCH_W-1:0]        raw_mask;
  logic                      found;
  logic [31:0]               taken_tgt;
  logic [31:0]               next_pc;
  logic [PW:0]               blk_cnt;
  logic [PW:0]               used;
  logic [PW:0]               free;
  logic                      grant;
  logic                      stall_after;

  nc_pred_table #(
    .FETCH_W    (FETCH_W),
    .BTB_ENTRIES(BTB_ENTRIES),
    .TAG_W      (TAG_W)
  ) u_pred (
    .clk        (clk),
    .resetn     (resetn),
    .upd_v_i    (upd_v_i),
    .upd_i      (upd_i),
    .lookup_pc_i(slot_pc),
    .lookup_o   (look)
  );

  assign start_slot = (pc_q >> 2) & 32'(FETCH_W - 1);

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) slot_pc[i] = (pc_q & ~BLOCK_MASK) + 32'(4 * i);
  end

  // Request slots from the entry slot up to and including the first
  // predicted-taken one; the block ends there.
  always_comb begin
    raw_mask  = '0;
    found     = 1'b0;
    taken_tgt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (!found && (32'(i) >= start_slot)) begin
        raw_mask[i] = 1'b1;
        if (look[i].taken) begin
          found     = 1'b1;
          taken_tgt = look[i].tgt;
        end
      end
    end
  end

  assign instr_req_o  = (state_q == FETCH) && !flush_i;
  assign instr_mask_o = instr_req_o ? raw_mask : '0;
  assign grant        = instr_req_o && instr_gnt_i;

  always_comb begin
    blk_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) blk_cnt = blk_cnt + (PW+1)'(instr_mask_o[i]);
  end

  // Pointer difference is taken modulo 2^(PW+1); the extra wrap bit lets
  // used reach IQ_DEPTH so a full queue is distinct from an empty one.
  assign used        = wr_ptr_q - iq_rd_ptr_i;
  assign free        = (PW+1)'(IQ_DEPTH) - used;
  assign stall_after = (int'(free) - int'(blk_cnt)) < FETCH_W;

  always_comb begin
    if (found) next_pc = ((pc_q & ~TAG_MASK) | (taken_tgt & TAG_MASK)) & ~32'h3;
    else       next_pc = pc_q + ((32'(FETCH_W) - start_slot) << 2);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH:    if (grant && stall_after) state_d = STALL;
      STALL:    if (int'(free) >= FETCH_W) state_d = FETCH;
      default:  state_d = RST_WAIT;
    endcase
    if (grant) pc_d = next_pc;
    // A redirect beats both the grant and the stall paths.
    if (flush_i) begin
      state_d = FETCH;
      pc_d    = branch_pc_i & ~32'h3;
    end
  end

  // The queue pointer is never rewound on flush; the consumer realigns its
  // read pointer instead.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= RST_WAIT;
      pc_q     <= PROGADDR_RESET & ~32'h3;
      wr_ptr_q <= '0;
      pred_v_q <= '0;
      pred_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pred_v_q <= grant ? instr_mask_o : '0;
      if (grant) begin
        wr_ptr_q <= wr_ptr_q + blk_cnt;
        pred_q   <= look;
      end
    end
  end

  assign instr_addr_o = pc_q;
  assign iq_wr_ptr_o  = wr_ptr_q;
  assign pred_v_o     = pred_v_q;
  assign pred_o       = pred_q;

endmodule
